// File: rtl/shl_seq_pkg.sv
// Shared definitions for the left-shift unit: state enum, op encoding, default widths.
package shl_seq_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned SHW_DEF   = 5;

  // Op encoding shared with the right-shifter wrapper.
  localparam logic OP_SLL = 1'b0;
  localparam logic OP_ROL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shl_seq_step.sv
// One-bit left shift (zero fill) or rotate, reused once per clock by shl_seq.
module shl_step
  import shl_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] res,
  input  logic             op,
  output logic [WIDTH-1:0] next_res,
  output logic             out_bit
);

  // Shift left by one; the MSB either wraps to bit 0 (ROL) or is dropped (SLL).
  always_comb begin
    out_bit  = res[WIDTH-1];
    next_res = {res[WIDTH-2:0], (op == OP_ROL) ? res[WIDTH-1] : 1'b0};
  end

endmodule

// File: rtl/shl_seq.sv
// Iterative SLL/ROL unit: one bit position per clock, valid/ready on both sides.
module shl_seq
  import shl_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src0,
  input  logic [SHW-1:0]   src1,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             last_out
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             last_q, last_d;

  logic [WIDTH-1:0] step_res;
  logic             step_bit;

  shl_step #(.WIDTH(WIDTH)) u_step (
    .res      (res_q),
    .op       (op_q),
    .next_res (step_res),
    .out_bit  (step_bit)
  );

  // Next-state, datapath update and handshake decode.
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    last_d    = last_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          res_d   = src0;
          cnt_d   = src1;
          op_d    = op;
          last_d  = 1'b0;
          state_d = (src1 == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        res_d  = step_res;
        last_d = step_bit;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      last_q  <= last_d;
    end
  end

  assign res      = res_q;
  assign last_out = last_q;

endmodule

// File: tb/tb_shl_seq.sv
// Self-checking bench for shl_seq: directed cases plus random ops against a shift/rotate model.
module tb_shl_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] src0 = '0;
  logic [4:0]  src1 = '0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic        last_out;

  int tests  = 0;
  int errors = 0;

  shl_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src0      (src0),
    .src1      (src1),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .last_out  (last_out)
  );

  always #5 clk = ~clk;

  // Reference: {last_out, res} from plain shift/rotate arithmetic.
  function automatic logic [32:0] model(input logic o, input logic [31:0] a, input int unsigned n);
    logic [63:0] w;
    logic [31:0] r;
    logic        l;
    if (n == 0) return {1'b0, a};
    w = {a, a} << n;
    r = o ? w[63:32] : (a << n);
    l = a[32-n];
    return {l, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, check latency and result, optionally hold off the consumer.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [4:0] n, input int unsigned bp);
    int unsigned lat;
    int unsigned w;
    logic [32:0] exp;
    logic [31:0] hold_res;
    logic        hold_last;
    exp = model(o, a, int'(n));
    w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    check("ready_before_req", {31'd0, in_ready}, 32'd1);
    out_ready = (bp == 0);
    in_valid = 1'b1; src0 = a; src1 = n; op = o;
    tick();
    in_valid = 1'b0;
    src0 = $urandom; src1 = 5'($urandom_range(31, 0)); op = 1'($urandom_range(1, 0));
    lat = 1;
    while (!out_valid && lat < 64) begin tick(); lat++; end
    check("latency", lat, int'(n) + 1);
    check("res", res, exp[31:0]);
    check("last_out", {31'd0, last_out}, {31'd0, exp[32]});
    if (bp > 0) begin
      hold_res = res; hold_last = last_out;
      for (int i = 0; i < int'(bp); i++) begin
        in_valid = (i % 2 == 0);
        src0 = $urandom; src1 = 5'($urandom_range(31, 1));
        tick();
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_ready", {31'd0, in_ready}, 32'd0);
        check("bp_res", res, hold_res);
        check("bp_last", {31'd0, last_out}, {31'd0, hold_last});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    check("idle_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [32:0] e2;
    int unsigned w;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_last", {31'd0, last_out}, 32'd0);

    // Directed cases
    run_op(1'b0, 32'h8000_0001, 5'd1, 0);
    check("sll1_const", res, 32'h0000_0002);
    run_op(1'b1, 32'h8000_0001, 5'd1, 0);
    check("rol1_const", res, 32'h0000_0003);
    run_op(1'b1, 32'h1234_5678, 5'd8, 0);
    check("rol8_const", res, 32'h3456_7812);
    run_op(1'b0, 32'hDEAD_BEEF, 5'd0, 0);
    run_op(1'b1, 32'hDEAD_BEEF, 5'd0, 0);
    check("zero_shift", res, 32'hDEAD_BEEF);
    run_op(1'b0, 32'h0000_0001, 5'd31, 0);
    check("sll31_const", res, 32'h8000_0000);

    // Backpressure with ignored requests
    run_op(1'b0, 32'h0000_000F, 5'd4, 5);
    check("bp_final", res, 32'h0000_00F0);
    run_op(1'b1, 32'hA5A5_0001, 5'd3, 0);

    // Reset mid-shift
    in_valid = 1'b1; src0 = 32'hFFFF_FFFF; src1 = 5'd20; op = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_ready", {31'd0, in_ready}, 32'd1);
    check("mrst_res", res, 32'd0);
    check("mrst_last", {31'd0, last_out}, 32'd0);
    run_op(1'b0, 32'h0000_0001, 5'd3, 0);
    check("post_rst", res, 32'h0000_0008);

    // Back-to-back with in_valid held high
    out_ready = 1'b1;
    in_valid = 1'b1; src0 = 32'h0000_0003; src1 = 5'd2; op = 1'b0;
    tick();
    src0 = 32'hF000_0000; src1 = 5'd4; op = 1'b1;
    w = 0;
    while (!out_valid && w < 64) begin tick(); w++; end
    check("b2b_a_res", res, 32'h0000_000C);
    check("b2b_a_last", {31'd0, last_out}, 32'd0);
    tick();
    check("b2b_idle", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_accept", {31'd0, in_ready}, 32'd0);
    w = 0;
    while (!out_valid && w < 64) begin tick(); w++; end
    check("b2b_b_lat", w, 32'd4);
    e2 = model(1'b1, 32'hF000_0000, 4);
    check("b2b_b_res", res, 32'h0000_000F);
    check("b2b_b_last", {31'd0, last_out}, {31'd0, e2[32]});
    tick();

    // Random operations
    for (int k = 0; k < 24; k++) begin
      run_op(1'($urandom_range(1, 0)), $urandom, 5'($urandom_range(31, 0)), $urandom_range(3, 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
